// File: rtl/serial_add2_ctrl.sv
// Start/busy/done sequencer around a single 2-bit add slice: WIDTH/2 steps per add,
// with carry registered between steps. Optional subtract mode via SERIAL_ADD_SUB_EN.
module serial_add2_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int N     = WIDTH / 2;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_reg, a_next;
    logic [WIDTH-1:0]   b_reg, b_next;
    logic [WIDTH-1:0]   acc_reg, acc_next;
    logic [WIDTH-1:0]   sum_reg, sum_next;
    logic               carry_reg, carry_next;
    logic               cout_reg, cout_next;
    logic [CNT_W-1:0]   count_reg, count_next;

    logic [WIDTH-1:0]   b_capture;
    logic               carry_init;
    logic [2:0]         slice_res;

    // Subtract is a + ~b + 1: invert B on capture and seed the carry with 1.
`ifdef SERIAL_ADD_SUB_EN
    assign b_capture  = sub ? ~b : b;
    assign carry_init = sub;
`else
    assign b_capture  = b;
    assign carry_init = 1'b0;
`endif

    assign slice_res = {1'b0, a_reg[1:0]} + {1'b0, b_reg[1:0]} + {2'b00, carry_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            acc_reg   <= acc_next;
            sum_reg   <= sum_next;
            carry_reg <= carry_next;
            cout_reg  <= cout_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        acc_next   = acc_reg;
        sum_next   = sum_reg;
        carry_next = carry_reg;
        cout_next  = cout_reg;
        count_next = count_reg;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next     = a;
                    b_next     = b_capture;
                    carry_next = carry_init;
                    count_next = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy       = 1'b1;
                a_next     = a_reg >> 2;
                b_next     = b_reg >> 2;
                acc_next   = acc_reg >> 2;
                acc_next[WIDTH-1 -: 2] = slice_res[1:0];
                carry_next = slice_res[2];
                count_next = count_reg + 1'b1;
                // Result is published only on the final step so sum stays stable mid-run.
                if (count_reg == CNT_W'(N - 1)) begin
                    sum_next   = acc_next;
                    cout_next  = slice_res[2];
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_serial_add2_ctrl.sv
// Self-checking bench for serial_add2_ctrl: timestamp-based reference model checked
// every cycle, plus directed transactions with literal expected results.
module tb_serial_add2_ctrl;

    localparam int WIDTH = 8;
    localparam int N     = WIDTH / 2;
`ifdef SERIAL_ADD_SUB_EN
    localparam bit HAS_SUB = 1'b1;
`else
    localparam bit HAS_SUB = 1'b0;
`endif

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic             sub   = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    serial_add2_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            passed++;
    endtask

    // Reference model: an add accepted at edge t is busy for edges t..t+N, done at t+N,
    // and the next request is only accepted from edge t+N+2.
    int         m_edge    = -1;
    int         m_acc     = 0;
    int         m_free    = 0;
    bit         m_act     = 1'b0;
    logic [8:0] m_pend    = '0;
    logic [8:0] m_shown   = '0;
    bit         mon_en    = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_edge  = -1;
            m_act   = 1'b0;
            m_free  = 0;
            m_pend  = '0;
            m_shown = '0;
        end else begin
            m_edge++;
            if (m_act && m_edge == m_acc + N)
                m_shown = m_pend;
            if ((!m_act || m_edge >= m_free) && start) begin
                m_act  = 1'b1;
                m_acc  = m_edge;
                m_free = m_edge + N + 2;
                if (HAS_SUB && sub)
                    m_pend = {1'b0, a} + {1'b0, ~b} + 9'd1;
                else
                    m_pend = {1'b0, a} + {1'b0, b};
            end
        end
    end

    always @(negedge clk) begin
        int k;
        bit e_busy, e_done;
        if (mon_en) begin
            k      = m_edge - m_acc;
            e_busy = m_act && k >= 0 && k <= N;
            e_done = m_act && k == N;
            chk("model_busy", 32'(busy), 32'(e_busy));
            chk("model_done", 32'(done), 32'(e_done));
            chk("model_sum",  32'(sum),  32'(m_shown[7:0]));
            chk("model_cout", 32'(cout), 32'(m_shown[8]));
        end
    end

    task automatic run_op(input string name, input logic [7:0] av, input logic [7:0] bv,
                          input logic sv, input logic [7:0] exp_sum, input logic exp_cout);
        int  lat;
        bit  got;
        @(negedge clk);
        a = av; b = bv; sub = sv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
        lat = 1;
        got = 1'b0;
        while (!got && lat < 20) begin
            if (done) got = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        if (!got) begin
            chk({name, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({name, "_latency"}, 32'(lat), 32'(N + 1));
            chk({name, "_sum"}, 32'(sum), 32'(exp_sum));
            chk({name, "_cout"}, 32'(cout), 32'(exp_cout));
            $display("op %s a=%h b=%h sub=%0d -> sum=%h cout=%0d latency=%0d",
                     name, av, bv, sv, sum, cout, lat);
        end
        @(negedge clk);
    endtask

    initial begin
        int dn;
        logic [7:0] s3;
        logic       c3;

        #1 rst_n = 1'b0;
        #1 mon_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_sum",  32'(sum),  32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;

        run_op("zero",   8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        run_op("alt55",  8'h55, 8'h55, 1'b0, 8'hAA, 1'b0);
        run_op("ripple", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op("maxmax", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1);

        // Start pulsed mid-run with new operands must be ignored.
        @(negedge clk);
        a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
        dn = 0; s3 = '0; c3 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (done) begin dn++; s3 = sum; c3 = cout; end
            if (i == 1) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
            if (i == 2) start = 1'b0;
        end
        chk("ignore_dones", 32'(dn), 32'd1);
        chk("ignore_sum",   32'(s3), 32'h46);
        chk("ignore_cout",  32'(c3), 32'd0);
        $display("op ignore a=12 b=34 with mid-run start -> dones=%0d sum=%h cout=%0d", dn, s3, c3);

        // Asynchronous reset in the second RUN cycle.
        @(negedge clk);
        a = 8'h80; b = 8'h80; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        chk("midreset_sum",  32'(sum),  32'd0);
        chk("midreset_cout", 32'(cout), 32'd0);
        $display("op midreset a=80 b=80 -> busy=%0d done=%0d sum=%h cout=%0d", busy, done, sum, cout);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_reset", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

        // Back-to-back with start held high: one accept every N+2 edges.
        @(negedge clk);
        start = 1'b1;
        dn = 0;
        for (int i = 0; i < 36; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            @(negedge clk);
            if (done) dn++;
        end
        start = 1'b0;
        chk("b2b_dones", 32'(dn), 32'd6);
        $display("op back_to_back 36 cycles -> dones=%0d", dn);
        repeat (N + 2) @(negedge clk);

`ifdef SERIAL_ADD_SUB_EN
        run_op("sub_neg", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0);
        run_op("sub_pos", 8'h07, 8'h05, 1'b1, 8'h02, 1'b1);
`endif

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            start = ($urandom_range(0, 2) == 0);
            a     = 8'($urandom);
            b     = 8'($urandom);
            sub   = 1'($urandom);
            if ($urandom_range(0, 149) == 0) #2 rst_n = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (N + 3) @(negedge clk);
        $display("random phase complete: 400 cycles");

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
